// File: rtl/fwd_stage_pipe.sv
// Producer side of the operand-forwarding path: EX/MEM/WB destination records,
// load-use bubble insertion and the data-memory load handshake.
package fwd_stage_pkg;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        rf_wr_en;
    logic        mem_read;
    logic [31:0] rd_data;
  } data_fwd_t;
endpackage

module fwd_stage_pipe
  import fwd_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_rf_wr_en_i,
  input  logic        id_mem_read_i,
  input  logic        flush_i,
  input  logic        load_use_hazard_i,
  input  logic [31:0] ex_result_i,
  output data_fwd_t   ex_stage_o,
  output data_fwd_t   mem_stage_o,
  output logic        stall_id_o,
  output logic        dmem_req_o,
  output logic [31:0] dmem_addr_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        wb_we_o
);

  localparam int DATA_W = 32;

  typedef enum logic {RUN = 1'b0, LD_WAIT = 1'b1} state_t;

  state_t state_q, state_d;

  logic              vld_p0, we_p0, ld_p0;
  logic [4:0]        rd_p0;
  logic              vld_p1, we_p1, ld_p1;
  logic [4:0]        rd_p1;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p2, we_p2;
  logic [4:0]        rd_p2;
  logic [DATA_W-1:0] data_p2;

  logic advance;
  logic bubble;

  // x0 is hard-wired zero, so a write to it must never be forwarded.
  function automatic logic wr_qualify(input logic [4:0] rd, input logic we);
    return we & (rd != 5'd0);
  endfunction

  assign advance = (state_q == RUN);
  assign bubble  = flush_i | load_use_hazard_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (vld_p0 && ld_p0) state_d = LD_WAIT;
      LD_WAIT: if (dmem_rvalid_i)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0  <= 1'b0;
      rd_p0   <= '0;
      we_p0   <= 1'b0;
      ld_p0   <= 1'b0;
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      we_p1   <= 1'b0;
      ld_p1   <= 1'b0;
      data_p1 <= '0;
      vld_p2  <= 1'b0;
      rd_p2   <= '0;
      we_p2   <= 1'b0;
      data_p2 <= '0;
    end else if (advance) begin
      // MEM -> WB
      vld_p2  <= vld_p1;
      rd_p2   <= rd_p1;
      we_p2   <= we_p1;
      data_p2 <= data_p1;
      // EX -> MEM
      vld_p1  <= vld_p0;
      rd_p1   <= rd_p0;
      we_p1   <= we_p0;
      ld_p1   <= ld_p0;
      data_p1 <= ex_result_i;
      // ID -> EX
      if (bubble || !id_valid_i) begin
        vld_p0 <= 1'b0;
        rd_p0  <= '0;
        we_p0  <= 1'b0;
        ld_p0  <= 1'b0;
      end else begin
        vld_p0 <= 1'b1;
        rd_p0  <= id_rd_i;
        we_p0  <= wr_qualify(id_rd_i, id_rf_wr_en_i);
        ld_p0  <= id_mem_read_i;
      end
    end else begin
      // Load outstanding: WB emits nothing so the held MEM record retires once.
      vld_p2 <= 1'b0;
      if (flush_i) vld_p0 <= 1'b0;
      if (dmem_rvalid_i) begin
        data_p1 <= dmem_rdata_i;
        ld_p1   <= 1'b0;
      end
    end
  end

  assign ex_stage_o  = '{valid: vld_p0, rd: rd_p0, rf_wr_en: we_p0,
                         mem_read: ld_p0, rd_data: ex_result_i};
  assign mem_stage_o = '{valid: vld_p1, rd: rd_p1, rf_wr_en: we_p1,
                         mem_read: ld_p1, rd_data: data_p1};

  assign stall_id_o  = !advance | (load_use_hazard_i & advance);
  assign dmem_req_o  = (state_q == LD_WAIT);
  assign dmem_addr_o = data_p1;

  assign wb_valid_o  = vld_p2;
  assign wb_rd_o     = rd_p2;
  assign wb_data_o   = data_p2;
  assign wb_we_o     = vld_p2 & we_p2;

endmodule

// File: tb/tb_fwd_stage_pipe.sv
// Directed bench for fwd_stage_pipe with a cycle-level reference model.
module tb_fwd_stage_pipe;
  import fwd_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rd = '0;
  logic        id_we = 1'b0;
  logic        id_mr = 1'b0;
  logic        flush = 1'b0;
  logic        hazard = 1'b0;
  logic [31:0] ex_result = '0;
  data_fwd_t   ex_stage, mem_stage;
  logic        stall, dmem_req;
  logic [31:0] dmem_addr;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;
  int n_dead = 0;
  bit cmp_en = 1'b0;

  fwd_stage_pipe dut (
    .clk_i(clk), .rst_i(rst),
    .id_valid_i(id_valid), .id_rd_i(id_rd), .id_rf_wr_en_i(id_we), .id_mem_read_i(id_mr),
    .flush_i(flush), .load_use_hazard_i(hazard), .ex_result_i(ex_result),
    .ex_stage_o(ex_stage), .mem_stage_o(mem_stage), .stall_id_o(stall),
    .dmem_req_o(dmem_req), .dmem_addr_o(dmem_addr),
    .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data), .wb_we_o(wb_we)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic we, input logic mr);
    id_valid = v;
    id_rd    = rd;
    id_we    = we;
    id_mr    = mr;
  endtask

  // Reference model: pipeline slots plus an outstanding-load flag.
  data_fwd_t m_ex = '0, m_mem = '0, m_wb = '0;
  bit        m_wait = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ex <= '0; m_mem <= '0; m_wb <= '0; m_wait <= 1'b0;
    end else if (!m_wait) begin
      m_wb   <= m_mem;
      m_mem  <= '{valid: m_ex.valid, rd: m_ex.rd, rf_wr_en: m_ex.rf_wr_en,
                  mem_read: m_ex.mem_read, rd_data: ex_result};
      m_wait <= m_ex.valid && m_ex.mem_read;
      if (flush || hazard || !id_valid) m_ex <= '0;
      else m_ex <= '{valid: 1'b1, rd: id_rd, rf_wr_en: id_we && (id_rd != 5'd0),
                     mem_read: id_mr, rd_data: 32'd0};
    end else begin
      m_wb <= '0;
      if (flush) m_ex.valid <= 1'b0;
      if (rvalid) begin
        m_mem.rd_data  <= rdata;
        m_mem.mem_read <= 1'b0;
        m_wait         <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (wb_valid === 1'b1 && wb_data === 32'hDEADBEEF) n_dead <= n_dead + 1;
    if (cmp_en) begin
      chk1("m.ex_valid", ex_stage.valid, m_ex.valid);
      if (m_ex.valid) begin
        chk32("m.ex_rd", {27'd0, ex_stage.rd}, {27'd0, m_ex.rd});
        chk1("m.ex_we", ex_stage.rf_wr_en, m_ex.rf_wr_en);
        chk1("m.ex_mr", ex_stage.mem_read, m_ex.mem_read);
      end
      chk1("m.mem_valid", mem_stage.valid, m_mem.valid);
      if (m_mem.valid) begin
        chk32("m.mem_rd", {27'd0, mem_stage.rd}, {27'd0, m_mem.rd});
        chk1("m.mem_we", mem_stage.rf_wr_en, m_mem.rf_wr_en);
        chk1("m.mem_mr", mem_stage.mem_read, m_mem.mem_read);
        chk32("m.mem_data", mem_stage.rd_data, m_mem.rd_data);
      end
      chk1("m.stall", stall, m_wait | hazard);
      chk1("m.dmem_req", dmem_req, m_wait);
      if (m_wait) chk32("m.dmem_addr", dmem_addr, m_mem.rd_data);
      chk1("m.wb_valid", wb_valid, m_wb.valid);
      if (m_wb.valid) begin
        chk32("m.wb_rd", {27'd0, wb_rd}, {27'd0, m_wb.rd});
        chk32("m.wb_data", wb_data, m_wb.rd_data);
        chk1("m.wb_we", wb_we, m_wb.rf_wr_en);
      end
    end
  end

  initial begin
    // Reset state
    step(); step();
    chk1("rst.ex_valid", ex_stage.valid, 1'b0);
    chk1("rst.mem_valid", mem_stage.valid, 1'b0);
    chk1("rst.wb_valid", wb_valid, 1'b0);
    chk1("rst.stall", stall, 1'b0);
    chk1("rst.dmem_req", dmem_req, 1'b0);
    chk32("rst.dmem_addr", dmem_addr, 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // ALU op rd=5 flowing EX -> MEM -> WB
    set_id(1, 5, 1, 0); step();
    set_id(0, 0, 0, 0); ex_result = 32'h11; #1;
    chk1("s1.ex_valid", ex_stage.valid, 1'b1);
    chk32("s1.ex_rd", {27'd0, ex_stage.rd}, 32'd5);
    chk32("s1.ex_data", ex_stage.rd_data, 32'h11);
    step(); ex_result = 32'h0; #1;
    chk1("s1.mem_valid", mem_stage.valid, 1'b1);
    chk32("s1.mem_data", mem_stage.rd_data, 32'h11);
    step(); #1;
    chk1("s1.wb_valid", wb_valid, 1'b1);
    chk32("s1.wb_rd", {27'd0, wb_rd}, 32'd5);
    chk32("s1.wb_data", wb_data, 32'h11);
    chk1("s1.wb_we", wb_we, 1'b1);
    step(); #1;
    chk1("s1.wb_once", wb_valid, 1'b0);

    // Load rd=3 with a dependent in ID, 3 wait cycles then data
    set_id(1, 3, 1, 1); step();
    set_id(1, 7, 1, 0); hazard = 1'b1; ex_result = 32'h100; #1;
    chk1("s2.stall_hz", stall, 1'b1);
    chk1("s2.ex_mr", ex_stage.mem_read, 1'b1);
    step(); hazard = 1'b0; #1;
    chk1("s2.ex_bubble", ex_stage.valid, 1'b0);
    chk1("s2.mem_valid", mem_stage.valid, 1'b1);
    chk1("s2.mem_mr", mem_stage.mem_read, 1'b1);
    chk1("s2.dmem_req", dmem_req, 1'b1);
    chk32("s2.dmem_addr", dmem_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      chk1("s3.stall_wait", stall, 1'b1);
      chk1("s3.req_wait", dmem_req, 1'b1);
      step(); #1;
    end
    rvalid = 1'b1; rdata = 32'hDEADBEEF; #1;
    chk1("s3.stall_rv", stall, 1'b1);
    step(); rvalid = 1'b0; rdata = 32'h0; #1;
    chk32("s3.mem_data", mem_stage.rd_data, 32'hDEADBEEF);
    chk1("s3.mem_mr", mem_stage.mem_read, 1'b0);
    chk1("s3.req_drop", dmem_req, 1'b0);
    chk1("s3.stall_rel", stall, 1'b0);
    step(); set_id(0, 0, 0, 0); ex_result = 32'h22; #1;
    chk1("s3.wb_valid", wb_valid, 1'b1);
    chk32("s3.wb_rd", {27'd0, wb_rd}, 32'd3);
    chk32("s3.wb_data", wb_data, 32'hDEADBEEF);
    chk32("s3.dep_rd", {27'd0, ex_stage.rd}, 32'd7);
    step(); step(); step(); #1;
    chk32("s3.wb_count", n_dead, 32'd1);

    // Load rd=9 with data in the first wait cycle
    set_id(1, 9, 1, 1); step();
    set_id(0, 0, 0, 0); ex_result = 32'h200; step();
    rvalid = 1'b1; rdata = 32'hCAFE0001; #1;
    chk1("s4.req", dmem_req, 1'b1);
    step(); rvalid = 1'b0; #1;
    chk1("s4.mem_held", mem_stage.valid, 1'b1);
    chk32("s4.mem_data", mem_stage.rd_data, 32'hCAFE0001);
    chk1("s4.req_drop", dmem_req, 1'b0);
    step(); #1;
    chk1("s4.wb_valid", wb_valid, 1'b1);
    chk32("s4.wb_data", wb_data, 32'hCAFE0001);
    step(); #1;
    chk1("s4.wb_once", wb_valid, 1'b0);

    // Back-to-back loads rd=10, rd=11
    set_id(1, 10, 1, 1); step();
    set_id(1, 11, 1, 1); ex_result = 32'h400; step();
    set_id(0, 0, 0, 0); rvalid = 1'b1; rdata = 32'hA; step();
    rvalid = 1'b0; ex_result = 32'h440; step(); #1;
    chk1("b2b.req", dmem_req, 1'b1);
    chk32("b2b.addr", dmem_addr, 32'h440);
    chk32("b2b.wb_data0", wb_data, 32'hA);
    rvalid = 1'b1; rdata = 32'hB; step();
    rvalid = 1'b0; step(); #1;
    chk32("b2b.wb_data1", wb_data, 32'hB);
    chk32("b2b.wb_rd1", {27'd0, wb_rd}, 32'd11);

    // Write to x0 must be squashed
    set_id(1, 0, 1, 0); step();
    set_id(0, 0, 0, 0); #1;
    chk1("s5.ex_valid", ex_stage.valid, 1'b1);
    chk1("s5.ex_we", ex_stage.rf_wr_en, 1'b0);
    step(); step(); #1;
    chk1("s5.wb_valid", wb_valid, 1'b1);
    chk1("s5.wb_we", wb_we, 1'b0);

    // Flush during LD_WAIT kills EX, load completes
    set_id(1, 4, 1, 1); step();
    set_id(1, 6, 1, 0); ex_result = 32'h300; step();
    set_id(0, 0, 0, 0); #1;
    chk1("s6.ex_before", ex_stage.valid, 1'b1);
    flush = 1'b1; step();
    flush = 1'b0; #1;
    chk1("s6.ex_flushed", ex_stage.valid, 1'b0);
    chk1("s6.req", dmem_req, 1'b1);
    rvalid = 1'b1; rdata = 32'h12345678; step();
    rvalid = 1'b0; #1;
    chk1("s6.req_drop", dmem_req, 1'b0);
    step(); #1;
    chk32("s6.wb_data", wb_data, 32'h12345678);
    chk32("s6.wb_rd", {27'd0, wb_rd}, 32'd4);
    step(); #1;
    chk1("s6.no_flushed_wb", wb_valid, 1'b0);

    // Simultaneous flush and hazard
    set_id(1, 12, 1, 0); step();
    set_id(1, 13, 1, 0); flush = 1'b1; hazard = 1'b1; #1;
    chk1("fh.stall", stall, 1'b1);
    step(); flush = 1'b0; hazard = 1'b0; set_id(0, 0, 0, 0); #1;
    chk1("fh.ex_bubble", ex_stage.valid, 1'b0);

    // Reset while a load is outstanding
    set_id(1, 8, 1, 1); step();
    set_id(0, 0, 0, 0); step(); #1;
    chk1("rl.req_before", dmem_req, 1'b1);
    rst = 1'b1; step();
    rst = 1'b0; #1;
    chk1("rl.req", dmem_req, 1'b0);
    chk1("rl.stall", stall, 1'b0);
    chk1("rl.ex_valid", ex_stage.valid, 1'b0);
    chk1("rl.mem_valid", mem_stage.valid, 1'b0);
    chk1("rl.wb_valid", wb_valid, 1'b0);
    rvalid = 1'b1; rdata = 32'h55; step();
    rvalid = 1'b0; step(); #1;
    chk1("rl.late_rv_mem", mem_stage.valid, 1'b0);
    chk1("rl.late_rv_wb", wb_valid, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_stage_pipe.md
Name: fwd_stage_pipe

Overview:
- Producer side of the operand-forwarding path. Owns the EX, MEM and WB destination-register records and drives the two `data_fwd_t` records consumed by the per-source-register forwarders.
- Acts on the load-use hazard those forwarders report: inserts a bubble and holds ID.
- Runs the data-memory load handshake, so load data is visible on the MEM forwarding record before any dependent instruction leaves ID.

Parameters:
- None. Widths are fixed: 5-bit register index, 32-bit data.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- id_valid_i  in  1  ID holds a real instruction.
- id_rd_i  in  5  destination register of the ID instruction.
- id_rf_wr_en_i  in  1  ID instruction writes the register file.
- id_mem_read_i  in  1  ID instruction is a load.
- flush_i  in  1  kill the ID instruction and the EX record (branch/jump redirect).
- load_use_hazard_i  in  1  OR of the load_use_hazard outputs of all source-register forwarders.
- ex_result_i  in  32  ALU result of the instruction in EX (load address for loads).
- ex_stage_o  out  data_fwd_t  EX record (valid, rd, rf_wr_en, mem_read from the EX register; rd_data = ex_result_i).
- mem_stage_o  out  data_fwd_t  MEM record, fully registered.
- stall_id_o  out  1  IF/ID must hold this cycle.
- dmem_req_o  out  1  load request to data memory.
- dmem_addr_o  out  32  load address (MEM record rd_data).
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  32  load data.
- wb_valid_o  out  1  write-back strobe, one cycle per retired instruction.
- wb_rd_o  out  5  write-back register.
- wb_data_o  out  32  write-back data.
- wb_we_o  out  1  register-file write enable (already qualified by wb_valid_o).

Behaviour:
- Reset: EX, MEM and WB records invalid with all fields 0; FSM in RUN; all outputs 0; stall_id_o=0.
- FSM states: RUN, LD_WAIT.
  - advance = (state==RUN).
  - stall_id_o = !advance | (load_use_hazard_i & advance).
- On advance, every rising edge:
  - WB <= MEM.
  - MEM <= EX, with rd_data captured from ex_result_i.
  - EX <= ID record, or a bubble (valid=0) if flush_i or load_use_hazard_i.
- Hazard case: the load moves EX->MEM, the bubble enters EX, ID holds. The dependent instruction then forwards from MEM.
- Not advancing (LD_WAIT):
  - EX and MEM hold.
  - WB is cleared to valid=0, so there is no duplicate write.
  - flush_i still invalidates EX.
  - load_use_hazard_i is ignored.
- Capture rule: rf_wr_en is forced to 0 when rd==0, so x0 is never forwarded.
- Load handshake:
  - Entering MEM a valid record with mem_read=1 moves RUN->LD_WAIT on the same edge.
  - In LD_WAIT: dmem_req_o=1 and dmem_addr_o=MEM.rd_data, both held stable until dmem_rvalid_i.
  - dmem_rvalid_i is accepted in any LD_WAIT cycle, including the first.
  - On dmem_rvalid_i in LD_WAIT: MEM.rd_data <= dmem_rdata_i, MEM.mem_read <= 0, state -> RUN. dmem_req_o drops on the following cycle.
  - Minimum load occupancy in MEM is 2 cycles: rvalid in the first LD_WAIT cycle, advance on the next.
  - dmem_rvalid_i outside LD_WAIT is ignored.
- Back-to-back loads: a load entering MEM on the advance out of a completed load re-enters LD_WAIT directly.
- Reset mid-load: returns to RUN, clears dmem_req_o and all records; the in-flight response is dropped.
- Simultaneous flush_i and load_use_hazard_i: EX takes the bubble; stall_id_o is still asserted per the formula.

Test Plan:
1. Reset, then ALU op rd=5 with ex_result_i=0x11 -> ex_stage_o {valid=1, rd=5, rd_data=0x11}; next cycle mem_stage_o.rd_data=0x11; next cycle wb_valid_o=1, wb_rd_o=5, wb_data_o=0x11.
2. Load rd=3 in EX, load_use_hazard_i=1 -> stall_id_o=1; next cycle EX valid=0, MEM holds the load, state LD_WAIT, dmem_req_o=1.
3. Same as scenario 2, then dmem_rvalid_i held low 3 cycles followed by rdata=0xDEADBEEF -> stall_id_o=1 throughout; mem_stage_o.rd_data=0xDEADBEEF with mem_read=0 one cycle after rvalid; wb_data_o=0xDEADBEEF exactly once.
4. dmem_rvalid_i high in the first LD_WAIT cycle -> load leaves MEM 2 cycles after entry; no duplicate wb_valid_o.
5. ID instruction with rd=0, rf_wr_en=1 -> ex_stage_o.rf_wr_en=0 and wb_we_o=0.
6. flush_i during LD_WAIT with a valid EX record -> EX becomes invalid; the MEM load completes normally. Assert rst_i in LD_WAIT -> next cycle dmem_req_o=0, state RUN, all valid=0.
